// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl
//
// Measurement controller for an enable-gated ring oscillator. A start request
// enables the ring and waits a settle window. It then counts synchronised
// rising edges of the ring output over a fixed gate window of system clocks,
// disables the ring, and reports the saturating edge count with a one-cycle
// done pulse.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous active-high reset
//   start    - measurement request, only honoured in idle
//   abort    - cancel a measurement in settle/measure (also blocks start in idle)
//   ring_clk - ring oscillator output, asynchronous to clk
//   ring_en  - ring oscillator enable, driven straight from a flop
//   busy     - high while settling or measuring
//   done     - one-cycle pulse, count/overflow valid in the same cycle
//   count    - rising edges seen in the last completed window, saturating
//   overflow - an edge was lost to saturation in the last completed window

module ring_osc_meas_ctrl #(
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ring_clk,
  output logic                 ring_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int unsigned GateW   = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GateW-1:0]     GateLast   = GateW'(GATE_CYCLES - 1);
  localparam logic [SettleW-1:0]   SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [GateW-1:0]     GateOne    = GateW'(1);
  localparam logic [SettleW-1:0]   SettleOne  = SettleW'(1);
  localparam logic [CNT_WIDTH-1:0] AccOne     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDone
  } state_e;

  state_e state_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   rise;

  logic [SettleW-1:0]   settle_cnt_q;
  logic [GateW-1:0]     gate_cnt_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic                 acc_ovf_q;
  logic [CNT_WIDTH-1:0] acc_d;
  logic                 acc_ovf_d;

  logic                 ring_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 overflow_q;

  // Synchroniser chain plus one extra flop holding the previous synchronised
  // value for rising-edge detection. Runs regardless of state; stale data left
  // over from a previous run is flushed by discarding edges during settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ring_clk};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Saturating accumulate. Overflow marks an edge that arrived while the
  // accumulator was already at its maximum, i.e. information was lost.
  always_comb begin
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    if (rise) begin
      if (acc_q == '1) begin
        acc_ovf_d = 1'b1;
      end else begin
        acc_d = acc_q + AccOne;
      end
    end
  end

  // Control FSM with all outputs registered so ring_en cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      acc_ovf_q    <= 1'b0;
      ring_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q      <= StSettle;
            ring_en_q    <= 1'b1;
            busy_q       <= 1'b1;
            settle_cnt_q <= '0;
            acc_q        <= '0;
            acc_ovf_q    <= 1'b0;
          end
        end

        StSettle: begin
          if (abort) begin
            state_q   <= StIdle;
            ring_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (settle_cnt_q == SettleLast) begin
            state_q    <= StMeasure;
            gate_cnt_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SettleOne;
          end
        end

        StMeasure: begin
          if (abort) begin
            state_q   <= StIdle;
            ring_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            if (gate_cnt_q == GateLast) begin
              // Load results from the next-state values so the edge seen in
              // the final gate cycle is included.
              state_q    <= StDone;
              ring_en_q  <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              count_q    <= acc_d;
              overflow_q <= acc_ovf_d;
            end else begin
              gate_cnt_q <= gate_cnt_q + GateOne;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q   <= StIdle;
          ring_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ring_en  = ring_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Bench for ring_osc_meas_ctrl. Two instances share clk/rst: dut_a uses a
// 16-bit counter, dut_b a 3-bit counter for saturation. Expected done
// responses are queued at stimulus time and checked by a monitor process.

module tb_ring_osc_meas_ctrl;

  localparam int unsigned Gate   = 64;
  localparam int unsigned Settle = 4;
  localparam int unsigned Lat    = 1 + Settle + Gate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, abort_a = 1'b0, ring_a = 1'b0;
  logic        start_b = 1'b0, abort_b = 1'b0, ring_b = 1'b0;
  logic        ring_en_a, busy_a, done_a, ovf_a;
  logic        ring_en_b, busy_b, done_b, ovf_b;
  logic [15:0] count_a;
  logic [2:0]  count_b;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int ndone_a = 0;
  int ndone_b = 0;
  int per_a = 8;
  int per_b = 4;
  int ph_a = 0;
  int ph_b = 0;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  ring_osc_meas_ctrl #(
    .GATE_CYCLES  (Gate),
    .SETTLE_CYCLES(Settle),
    .SYNC_STAGES  (2),
    .CNT_WIDTH    (16)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start_a),
    .abort   (abort_a),
    .ring_clk(ring_a),
    .ring_en (ring_en_a),
    .busy    (busy_a),
    .done    (done_a),
    .count   (count_a),
    .overflow(ovf_a)
  );

  ring_osc_meas_ctrl #(
    .GATE_CYCLES  (Gate),
    .SETTLE_CYCLES(Settle),
    .SYNC_STAGES  (2),
    .CNT_WIDTH    (3)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start_b),
    .abort   (abort_b),
    .ring_clk(ring_b),
    .ring_en (ring_en_b),
    .busy    (busy_b),
    .done    (done_b),
    .count   (count_b),
    .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ring models: square wave with 50% duty, running only while enabled.
  always @(negedge clk) begin
    if (ring_en_a) begin
      ring_a = (ph_a % per_a) < (per_a / 2);
      ph_a++;
    end else begin
      ring_a = 1'b0;
      ph_a = 0;
    end
    if (ring_en_b) begin
      ring_b = (ph_b % per_b) < (per_b / 2);
      ph_b++;
    end else begin
      ring_b = 1'b0;
      ph_b = 0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      ndone_a++;
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'(done_a), 32'd0);
      end else begin
        e_a = q_a.pop_front();
        chk("a_done_cycle", 32'(cyc), 32'(e_a.cyc));
        chk("a_count", 32'(count_a), 32'(e_a.cnt));
        chk("a_overflow", 32'(ovf_a), 32'(e_a.ovf));
        chk("a_busy_at_done", 32'(busy_a), 32'd0);
        chk("a_ring_en_at_done", 32'(ring_en_a), 32'd0);
      end
    end
    if (done_b === 1'b1) begin
      ndone_b++;
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'(done_b), 32'd0);
      end else begin
        e_b = q_b.pop_front();
        chk("b_done_cycle", 32'(cyc), 32'(e_b.cyc));
        chk("b_count", 32'(count_b), 32'(e_b.cnt));
        chk("b_overflow", 32'(ovf_b), 32'(e_b.ovf));
        chk("b_busy_at_done", 32'(busy_b), 32'd0);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_idle_a(input string tag, input logic [15:0] cnt);
    chk({tag, "_ring_en"}, 32'(ring_en_a), 32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_count"}, 32'(count_a), 32'(cnt));
    chk({tag, "_overflow"}, 32'(ovf_a), 32'd0);
  endtask

  // Pulse start for one cycle; optionally queue the expected result.
  task automatic launch_a(input int per, input bit push, input logic [15:0] cnt,
                          input logic ovf, output int d);
    exp_t e;
    per_a = per;
    start_a = 1'b1;
    d = cyc;
    if (push) begin
      e.cyc = d + Lat;
      e.cnt = cnt;
      e.ovf = ovf;
      q_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic launch_b(input int per, input logic [15:0] cnt, input logic ovf);
    exp_t e;
    per_b = per;
    start_b = 1'b1;
    e.cyc = cyc + Lat;
    e.cnt = cnt;
    e.ovf = ovf;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    int d;
    int nd;

    // Test 1: reset held three cycles, then idle.
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle_a("rst_hold", 16'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk_idle_a("idle", 16'd0);
    end

    // Test 2: nominal measurement, period 8 -> 8 edges in 64 cycles.
    launch_a(8, 1'b1, 16'd8, 1'b0, d);
    chk("run_busy", 32'(busy_a), 32'd1);
    chk("run_ring_en", 32'(ring_en_a), 32'd1);
    wait_until(d + Lat + 1);
    chk("after_done_ring_en", 32'(ring_en_a), 32'd0);
    chk("after_done_count_hold", 32'(count_a), 32'd8);

    // Test 5a: start again during a run is ignored.
    repeat (3) @(negedge clk);
    nd = ndone_a;
    launch_a(8, 1'b1, 16'd8, 1'b0, d);
    wait_until(d + 10);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_until(d + Lat + 20);
    chk("single_done", 32'(ndone_a - nd), 32'd1);

    // Test 5b: start and abort together in idle.
    start_a = 1'b1;
    abort_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_abort_ring_en", 32'(ring_en_a), 32'd0);
      chk("start_abort_busy", 32'(busy_a), 32'd0);
    end
    start_a = 1'b0;
    abort_a = 1'b0;

    // Test 4: abort during measure keeps previous results.
    @(negedge clk);
    nd = ndone_a;
    launch_a(4, 1'b0, 16'd0, 1'b0, d);
    wait_until(d + 30);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_ring_en", 32'(ring_en_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    repeat (100) @(negedge clk);
    chk("abort_no_done", 32'(ndone_a - nd), 32'd0);
    chk("abort_count_kept", 32'(count_a), 32'd8);
    chk("abort_ovf_kept", 32'(ovf_a), 32'd0);

    // Test 3: saturation on the 3-bit instance, then a non-saturating run.
    launch_b(4, 16'd7, 1'b1);
    repeat (Lat + 4) @(negedge clk);
    launch_b(16, 16'd4, 1'b0);
    repeat (Lat + 4) @(negedge clk);
    chk("b_two_dones", 32'(ndone_b), 32'd2);

    // Test 6: reset mid-run clears everything, then a fresh run completes.
    launch_a(8, 1'b0, 16'd0, 1'b0, d);
    wait_until(d + 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_a("mid_rst", 16'd0);
    chk("mid_rst_b_count", 32'(count_b), 32'd0);
    @(negedge clk);
    launch_a(8, 1'b1, 16'd8, 1'b0, d);
    wait_until(d + Lat + 5);

    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
